// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the byte-stream-to-RAM loader.
package ram_loader_pkg;

    // Loader control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Bytes assembled into one RAM word.
    localparam int BYTES_PER_WORD = 4;

    // Width of the assembled word coming out of the packer.
    localparam int WORD_BITS = BYTES_PER_WORD * 8;

    // Width of the byte index inside a word.
    localparam int BYTE_IDX_W = $clog2(BYTES_PER_WORD);

    // Index of the final byte of a word.
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/ram_loader_if.sv
// Bundle of the load-control, byte-stream and RAM-side signals of the loader.
interface ram_loader_if
    import ram_loader_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] base_addr;
    logic [WIDTH-1:0] word_count;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ram_address;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_enw;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] checksum;

    // The side that requests loads and supplies bytes.
    modport master (
        output start, base_addr, word_count, in_data, in_valid,
        input  in_ready, ram_address, ram_wdata, ram_enw, busy, done, checksum
    );

    // The loader itself.
    modport slave (
        input  start, base_addr, word_count, in_data, in_valid,
        output in_ready, ram_address, ram_wdata, ram_enw, busy, done, checksum
    );

endinterface

// File: rtl/ram_loader_word_packer.sv
// Assembles incoming bytes little-endian into one word and flags when it is complete.
module word_packer
    import ram_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_in,
    output logic [WORD_BITS-1:0] word,
    output logic                 full,
    output logic                 last_byte
);

    logic [WORD_BITS-1:0]  word_q, word_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic                  full_q, full_d;

    // Place each accepted byte in its lane; a clear restarts at byte 0 but keeps the old word visible.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        full_d = full_q;
        if (clear) begin
            idx_d  = '0;
            full_d = 1'b0;
        end else if (byte_valid) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_in;
            if (idx_q == LAST_BYTE_IDX) begin
                idx_d  = '0;
                full_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            full_q <= full_d;
        end
    end

    assign word      = word_q;
    assign full      = full_q;
    assign last_byte = byte_valid && !clear && (idx_q == LAST_BYTE_IDX);

endmodule

// File: rtl/ram_loader.sv
// Loads a byte stream into consecutive RAM words starting at a base index, keeping a running checksum.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic         clk,
    input  logic         rst,
    ram_loader_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] word_idx_q, word_idx_d;
    logic [WIDTH-1:0] checksum_q, checksum_d;
    logic             done_q, done_d;

    logic                 pk_clear;
    logic                 pk_accept;
    logic [WORD_BITS-1:0] pk_word;
    logic                 pk_full;
    logic                 pk_last;
    logic [WIDTH-1:0]     packed_ext;

    assign pk_accept  = bus.in_valid && (state_q == COLLECT);
    assign packed_ext = WIDTH'(pk_word);

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .byte_valid (pk_accept),
        .byte_in    (bus.in_data),
        .word       (pk_word),
        .full       (pk_full),
        .last_byte  (pk_last)
    );

    // Next-state and control decode; the done pulse is registered so it lands one cycle after DONE.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        checksum_d = checksum_q;
        pk_clear   = 1'b0;
        done_d     = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d     = bus.base_addr;
                    count_d    = bus.word_count;
                    checksum_d = '0;
                    word_idx_d = '0;
                    pk_clear   = 1'b1;
                    state_d    = (bus.word_count != '0) ? COLLECT : DONE;
                end
            end
            COLLECT: begin
                if (pk_last) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                checksum_d = checksum_q + packed_ext;
                pk_clear   = 1'b1;
                if (word_idx_q == count_q - ONE) begin
                    state_d = DONE;
                end else begin
                    word_idx_d = word_idx_q + ONE;
                    state_d    = COLLECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and datapath registers; reset abandons any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
            checksum_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            checksum_q <= checksum_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready    = (state_q == COLLECT);
    assign bus.ram_enw     = (state_q == WRITE) && pk_full;
    assign bus.ram_address = base_q + word_idx_q;
    assign bus.ram_wdata   = packed_ext;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.checksum    = checksum_q;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: expected writes and checksums are queued by the stimulus and popped by a monitor.
module tb_ram_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    ram_loader_if #(.WIDTH(32)) bus ();

    ram_loader #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] sum_q[$];

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    int n_done = 0;
    int last_write_cyc = 0;
    int last_done_cyc = 0;
    int acc_cyc = 0;
    int start_cyc = 0;
    bit ready_seen = 0;

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s timeout", name);
    endtask

    // Monitor: compares every RAM write and every done pulse against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_ready) ready_seen = 1;
            if (bus.ram_enw) begin
                wr_t e;
                n_writes++;
                last_write_cyc = cyc;
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_write");
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", bus.ram_address, e.addr);
                    check("write_data", bus.ram_wdata, e.data);
                end
            end
            if (bus.done) begin
                n_done++;
                last_done_cyc = cyc;
                if (sum_q.size() == 0) begin
                    timeout_fail("unexpected_done");
                end else begin
                    check("checksum", bus.checksum, sum_q.pop_front());
                end
            end
        end
    end

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [31:0] count);
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = count;
        start_cyc      = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                acc_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) timeout_fail("send_byte");
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (gaps) idle_cycle();
        end
    endtask

    task automatic wait_done(input int prev);
        bit ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(posedge clk); #1;
            if (n_done > prev) ok = 1;
        end
        if (!ok) timeout_fail("wait_done");
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_ram_enw"}, bus.ram_enw, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_checksum"}, bus.checksum, 0);
        check({tag, "_ram_address"}, bus.ram_address, 0);
        check({tag, "_ram_wdata"}, bus.ram_wdata, 0);
        @(posedge clk); #1;
    endtask

    // Directed stimulus sequence.
    initial begin
        int prev;
        int wprev;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        idle_cycle();

        // Single word, back-to-back bytes.
        exp_q.push_back('{addr: 32'h10, data: 32'h12345678});
        sum_q.push_back(32'h12345678);
        prev = n_done;
        do_start(32'h10, 32'd1);
        send_word(32'h12345678, 0);
        wait_done(prev);
        check("enw_latency", last_write_cyc - acc_cyc, 1);
        check("done_after_write", last_done_cyc - last_write_cyc, 2);
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        @(posedge clk); #1;

        // Three words with 50% valid gaps and an ignored start during COLLECT.
        exp_q.push_back('{addr: 32'h200, data: 32'hDEADBEEF});
        exp_q.push_back('{addr: 32'h201, data: 32'h01020304});
        exp_q.push_back('{addr: 32'h202, data: 32'hA5A5F00F});
        sum_q.push_back(32'h8555B202);
        prev = n_done;
        do_start(32'h200, 32'd3);
        send_byte(8'hEF);
        bus.in_valid   = 1'b0;
        bus.start      = 1'b1;
        bus.base_addr  = 32'h999;
        bus.word_count = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("busy_mid_load", bus.busy, 1);
        @(posedge clk); #1;
        send_byte(8'hBE);
        idle_cycle();
        send_byte(8'hAD);
        idle_cycle();
        send_byte(8'hDE);
        idle_cycle();
        send_word(32'h01020304, 1);
        send_word(32'hA5A5F00F, 1);
        wait_done(prev);

        // Zero count.
        sum_q.push_back(32'h0);
        prev = n_done;
        wprev = n_writes;
        ready_seen = 0;
        do_start(32'h50, 32'd0);
        wait_done(prev);
        check("zero_done_after_start", last_done_cyc - start_cyc, 2);
        check("zero_no_write", n_writes - wprev, 0);
        check("zero_no_ready", ready_seen, 0);

        // Address wrap.
        exp_q.push_back('{addr: 32'hFFFFFFFF, data: 32'h11111111});
        exp_q.push_back('{addr: 32'h00000000, data: 32'h22222222});
        sum_q.push_back(32'h33333333);
        prev = n_done;
        do_start(32'hFFFFFFFF, 32'd2);
        send_word(32'h11111111, 0);
        send_word(32'h22222222, 0);
        wait_done(prev);

        // Reset after two bytes of word 2, then a fresh load.
        exp_q.push_back('{addr: 32'h300, data: 32'hCAFEBABE});
        prev = n_done;
        do_start(32'h300, 32'd3);
        send_word(32'hCAFEBABE, 0);
        send_byte(8'h01);
        send_byte(8'h02);
        wprev = n_writes;
        repeat (3) idle_cycle();
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        rst = 1'b0;
        repeat (5) idle_cycle();
        check("midreset_no_write", n_writes - wprev, 0);
        check("midreset_no_done", n_done - prev, 0);
        check("midreset_first_word_written", exp_q.size(), 0);

        exp_q.push_back('{addr: 32'h400, data: 32'h0BADF00D});
        sum_q.push_back(32'h0BADF00D);
        prev = n_done;
        do_start(32'h400, 32'd1);
        send_word(32'h0BADF00D, 0);
        wait_done(prev);

        repeat (3) idle_cycle();
        check("writes_left", exp_q.size(), 0);
        check("sums_left", sum_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning RAM data and address width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high; the block has one clock only.
REQ-004 SHALL have port start  input  1  load request, sampled only in IDLE.
REQ-005 SHALL have port base_addr  input  WIDTH  first RAM word index, captured on accepted start.
REQ-006 SHALL have port word_count  input  WIDTH  number of words to load, captured on accepted start.
REQ-007 SHALL have port in_data  input  8  byte from the serial/host source.
REQ-008 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-009 SHALL have port in_ready  output  1  block accepts a byte this cycle.
REQ-010 SHALL have port ram_address  output  WIDTH  word index driven to the RAM address port.
REQ-011 SHALL have port ram_wdata  output  WIDTH  assembled word driven to the RAM write-data port.
REQ-012 SHALL have port ram_enw  output  1  RAM write enable.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE; holds the CPU off the RAM.
REQ-014 SHALL have port done  output  1  one-cycle pulse at load completion.
REQ-015 SHALL have port checksum  output  WIDTH  sum of all words written in the current load, mod 2^WIDTH.

Function
REQ-016 SHALL implement states IDLE, COLLECT, WRITE and DONE.
REQ-017 SHALL transition on start in IDLE: capture base_addr and word_count, clear checksum, clear byte index and word index, then go to COLLECT if word_count != 0, else go to DONE.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL drive in_ready=1 only in COLLECT; a byte transfers only when in_valid && in_ready.
REQ-020 SHALL pack bytes little-endian: byte k (k=0..3) of a word goes to ram_wdata[8k+7:8k].
REQ-021 SHALL go to WRITE on the cycle after the 4th byte is accepted; latency from 4th-byte acceptance to ram_enw=1 is exactly 1 cycle.
REQ-022 SHALL in WRITE assert ram_enw=1 for exactly one cycle, with ram_address=base+word_idx (mod 2^WIDTH) and the packed word on ram_wdata.
REQ-023 SHALL in that same WRITE cycle add the written word to checksum.
REQ-024 SHALL leave WRITE to DONE if word_idx == count-1; otherwise increment word_idx, clear the byte index and return to COLLECT.
REQ-025 SHALL in DONE assert done=1 for one cycle, then go to IDLE; checksum holds its value until the next accepted start.
REQ-026 SHALL keep ram_enw=0 outside WRITE; ram_address and ram_wdata may hold their values while ram_enw=0.
REQ-027 SHALL tolerate in_valid gaps: COLLECT waits indefinitely and the partial word is retained.
REQ-028 SHALL wrap ram_address past 2^WIDTH-1 to 0 without error.
REQ-029 SHALL give a minimum throughput of 5 cycles per word (4 COLLECT + 1 WRITE).

Reset
REQ-030 SHALL on rst=1 at a clock edge enter IDLE and drive in_ready=0, ram_enw=0, busy=0, done=0, checksum=0, ram_address=0 and ram_wdata=0.
REQ-031 SHALL on reset mid-load discard the partial word and issue no further write; words already written remain in RAM.
REQ-032 SHALL give rst priority over start and in_valid in the same cycle.

Structure
REQ-033 SHALL place the state enum (IDLE/COLLECT/WRITE/DONE) and the constant BYTES_PER_WORD=4 in the shared package ram_loader_pkg.
REQ-034 SHALL keep byte packing in one natural sub-module, word_packer: byte shift-in, byte index, and a full flag.
REQ-035 SHALL fit in 120-400 lines of RTL with no memory inferred inside the block.

Verification
REQ-036 SHALL cover single word: base=0x10, count=1, bytes 0x78,0x56,0x34,0x12 back-to-back -> one ram_enw at address 0x10 with wdata 0x12345678, checksum 0x12345678, done pulse 2 cycles after the write.
REQ-037 SHALL cover multi-word with gaps: count=3, in_valid toggling 50% -> writes at base, base+1, base+2 in order, data correct, checksum = sum of the three words.
REQ-038 SHALL cover zero count: start with count=0 -> no ram_enw, in_ready never 1, done exactly 2 cycles after start.
REQ-039 SHALL cover wrap: base=0xFFFFFFFF, count=2 -> writes at 0xFFFFFFFF then 0x00000000.
REQ-040 SHALL cover reset mid-load: rst after 2 bytes of word 2 -> no further ram_enw, all outputs at reset values; a fresh start then loads correctly from byte 0.
REQ-041 SHALL cover start while busy: start pulsed during COLLECT with different base_addr -> ignored, original addresses used.
